// File: rtl/cache_controller.sv
// Write-back/write-allocate controller for a 64-entry direct-mapped word cache. Hit completes in 2 cycles, a miss adds the memory latency plus one cycle, and a dirty miss also adds the writeback.
// Backpressure: cpu_busy stays high until the request completes, and any cpu_req seen while busy is dropped.
module cache_controller #(
   parameter int INDEX_W = 6,
   parameter int TAG_W   = 10,
   parameter int CNT_W   = 32
) (
   input  logic             clk,
   input  logic             rst_b,
   input  logic             cpu_req,
   input  logic             cpu_we,
   input  logic [31:0]      cpu_addr,
   input  logic [31:0]      cpu_wdata,
   output logic             cpu_busy,
   output logic             cpu_done,
   output logic [31:0]      cpu_rdata,
   output logic [31:0]      cache_addr,
   output logic [31:0]      cache_wdata,
   output logic             we_cache,
   output logic             set_valid,
   output logic             set_dirty,
   input  logic             cache_hit,
   input  logic             cache_dirty,
   input  logic [31:0]      cache_rdata,
   input  logic [31:0]      cache_wb_addr,
   output logic [31:0]      mem_addr,
   output logic [31:0]      mem_wdata,
   output logic             mem_re,
   output logic             mem_we,
   input  logic [31:0]      mem_rdata,
   input  logic             mem_ready,
   output logic [CNT_W-1:0] hit_count,
   output logic [CNT_W-1:0] miss_count
);
   localparam int DEPTH = 2 ** INDEX_W;
   localparam int AW    = INDEX_W + TAG_W;

   typedef enum logic [1:0] {S_IDLE, S_COMPARE, S_WRITEBACK, S_ALLOCATE} state_t;

   state_t             r_state;
   logic [31:0]        r_addr;
   logic [31:0]        r_wdata;
   logic               r_we;
   logic               r_first;
   logic [DEPTH-1:0]   r_valid;
   logic               r_cpu_done;
   logic [31:0]        r_cpu_rdata;
   logic [CNT_W-1:0]   r_hit_count;
   logic [CNT_W-1:0]   r_miss_count;

   logic [INDEX_W-1:0] w_idx;
   logic               w_vld;
   logic               w_hit;
   logic               w_dirty;

   // The cache's own valid bit survives reset; only the shadow is trusted.
   assign w_idx   = r_addr[INDEX_W-1:0];
   assign w_vld   = r_valid[w_idx];
   assign w_hit   = cache_hit & w_vld;
   assign w_dirty = cache_dirty & w_vld;

   assign cache_addr = {{(32-AW){1'b0}}, r_addr[AW-1:0]};
   assign cpu_busy   = (r_state != S_IDLE);
   assign cpu_done   = r_cpu_done;
   assign cpu_rdata  = r_cpu_rdata;
   assign hit_count  = r_hit_count;
   assign miss_count = r_miss_count;

   always_comb begin
      set_valid   = w_vld;
      set_dirty   = w_dirty;
      we_cache    = 1'b0;
      cache_wdata = r_wdata;
      mem_addr    = 32'h0;
      mem_wdata   = 32'h0;
      mem_re      = 1'b0;
      mem_we      = 1'b0;
      case (r_state)
         S_COMPARE: begin
            if (w_hit && r_we) begin
               we_cache  = 1'b1;
               set_valid = 1'b1;
               set_dirty = 1'b1;
            end
         end
         S_WRITEBACK: begin
            mem_we    = 1'b1;
            mem_addr  = cache_wb_addr;
            mem_wdata = cache_rdata;
         end
         S_ALLOCATE: begin
            mem_re   = 1'b1;
            mem_addr = r_addr;
            // Fill lands in the cache on the same edge memory completes.
            if (mem_ready) begin
               we_cache    = 1'b1;
               cache_wdata = mem_rdata;
               set_valid   = 1'b1;
               set_dirty   = 1'b0;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         r_state      <= S_IDLE;
         r_addr       <= 32'h0;
         r_wdata      <= 32'h0;
         r_we         <= 1'b0;
         r_first      <= 1'b0;
         r_valid      <= '0;
         r_cpu_done   <= 1'b0;
         r_cpu_rdata  <= 32'h0;
         r_hit_count  <= '0;
         r_miss_count <= '0;
      end else begin
         r_cpu_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (cpu_req) begin
                  r_addr  <= cpu_addr;
                  r_we    <= cpu_we;
                  r_wdata <= cpu_wdata;
                  r_first <= 1'b1;
                  r_state <= S_COMPARE;
               end
            end
            S_COMPARE: begin
               r_first <= 1'b0;
               if (r_first) begin
                  if (w_hit) r_hit_count  <= r_hit_count + CNT_W'(1);
                  else       r_miss_count <= r_miss_count + CNT_W'(1);
               end
               if (w_hit) begin
                  if (!r_we) r_cpu_rdata <= cache_rdata;
                  r_cpu_done <= 1'b1;
                  r_state    <= S_IDLE;
               end else if (w_dirty) begin
                  r_state <= S_WRITEBACK;
               end else begin
                  r_state <= S_ALLOCATE;
               end
            end
            S_WRITEBACK: begin
               if (mem_ready) r_state <= S_ALLOCATE;
            end
            S_ALLOCATE: begin
               if (mem_ready) begin
                  r_valid[w_idx] <= 1'b1;
                  r_state        <= S_COMPARE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end
endmodule
